sim_dev_link: RTL
=================

SIM_DEV_LINK -- requirements
Module: sim_dev_link

Interface
REQ-001 Parameter TX_PERIOD, default 100000: cycles between periodic command frames (>=2).
REQ-002 Parameter CHANGE_TX, default 1: 1 = also send a frame as soon as the command byte differs from the last accepted one.
REQ-003 Parameter NUM_DET, default 4: number of detector channels, 1..4, taken from rx_data[NUM_DET-1:0].
REQ-004 Parameter DEBOUNCE_N, default 3: consecutive agreeing received samples required to change a detector output (1..15).
REQ-005 Parameter TIMEOUT, default 10000000: cycles without rx_valid before the link is declared down.
REQ-006 Parameter HDR, default 2'b10: header bits placed in tx_data[7:6].
REQ-007 sys_clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous, active-low reset.
REQ-009 power  in  1  car power; 0 forces moving field to 0000.
REQ-010 moving_state  in  4  motion command bits.
REQ-011 place_barrier  in  1  one-cycle request pulse.
REQ-012 destroy_barrier  in  1  one-cycle request pulse.
REQ-013 tx_data  out  8  frame {HDR, destroy, place, moving}.
REQ-014 tx_valid  out  1  frame offered to UART transmitter.
REQ-015 tx_ready  in  1  transmitter accepts when tx_valid&&tx_ready.
REQ-016 rx_data  in  8  received byte.
REQ-017 rx_valid  in  1  one-cycle strobe, rx_data valid.
REQ-018 detector  out  NUM_DET  debounced detector bits (bit0 front, 1 left, 2 right, 3 back).
REQ-019 link_up  out  1  1 while rx bytes arrive within TIMEOUT.
REQ-020 frame_cnt  out  16  count of accepted tx frames, wraps 0xFFFF->0.

Function
REQ-021 Tx FSM states IDLE, SEND; IDLE->SEND on trigger; SEND->IDLE on tx_valid&&tx_ready in same cycle.
REQ-022 Trigger = period counter reaching TX_PERIOD-1, or (CHANGE_TX and current command byte != last accepted byte).
REQ-023 Period counter increments every cycle, restarts at 0 on trigger; a trigger while in SEND is held until return to IDLE, not dropped.
REQ-024 tx_data is registered on IDLE->SEND and held stable while tx_valid=1.
REQ-025 place/destroy pulses set sticky pending bits; pending bits go into the frame and clear only on acceptance of that frame.
REQ-026 A pulse coinciding with acceptance leaves its pending bit set for the next frame.
REQ-027 Any pending bit set while IDLE counts as a trigger.
REQ-028 Moving field = moving_state when power=1, else 4'b0000.
REQ-029 frame_cnt increments by 1 on each acceptance.
REQ-030 Per channel: on rx_valid, if bit equals candidate increment agree counter (saturating at DEBOUNCE_N), else load candidate and set counter to 1; detector bit updates to candidate when counter reaches DEBOUNCE_N.
REQ-031 Watchdog counter clears on rx_valid, otherwise increments saturating at TIMEOUT; link_up = (counter < TIMEOUT).
REQ-032 While link_up=0, detector outputs all ones (fail-safe: obstacle everywhere); debounce state is reset so recovery requires DEBOUNCE_N fresh samples.
REQ-033 Latency: detector change visible the cycle after the DEBOUNCE_N-th agreeing rx_valid.

Reset
REQ-034 On rst=0: FSM IDLE, tx_valid=0, tx_data=0, pending bits 0, period counter 0, last-sent byte 0, frame_cnt=0.
REQ-035 On rst=0: detector=0, debounce counters 0, watchdog 0, link_up=1.
REQ-036 Reset asserted mid-SEND drops the frame; no acceptance counted.

Structure
REQ-037 FSM state encoding and frame-field bit positions SHALL live in shared package sim_link_pkg.
REQ-038 Per-channel debounce SHALL be sub-module det_debounce, instantiated NUM_DET times.

Verification
REQ-039 Reset, tx_ready=1, power=1, moving=0101, CHANGE_TX=1 -> one frame 8'b10000101, frame_cnt=1.
REQ-040 tx_ready=0 for 10 cycles after trigger -> tx_valid high, tx_data stable all 10 cycles, one acceptance only.
REQ-041 place pulse on acceptance cycle of prior frame -> next frame has bit4=1, then pending clears.
REQ-042 DEBOUNCE_N=3, rx bytes 0x01,0x01,0x00,0x01,0x01,0x01 -> detector[0] rises only after 6th byte.
REQ-043 TIMEOUT=100, no rx_valid for 100 cycles -> link_up=0, detector=all ones; then 3 bytes 0x00 -> link_up=1, detector=0.
REQ-044 power=0 with moving=1111 -> frame moving field 0000.

Source files
------------

// File: rtl/sim_link_pkg.sv
// Shared definitions for the sim device link: tx FSM encoding and command frame layout.
package sim_link_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    localparam int FRM_HDR_MSB  = 7;
    localparam int FRM_HDR_LSB  = 6;
    localparam int FRM_DESTROY  = 5;
    localparam int FRM_PLACE    = 4;
    localparam int FRM_MOVE_MSB = 3;
    localparam int FRM_MOVE_LSB = 0;

    function automatic logic [7:0] build_frame(
        input logic [1:0] hdr,
        input logic       destroy,
        input logic       place,
        input logic [3:0] moving
    );
        logic [7:0] f;
        f = '0;
        f[FRM_HDR_MSB:FRM_HDR_LSB]   = hdr;
        f[FRM_DESTROY]               = destroy;
        f[FRM_PLACE]                 = place;
        f[FRM_MOVE_MSB:FRM_MOVE_LSB] = moving;
        return f;
    endfunction

endpackage

// File: rtl/det_debounce.sv
// One detector channel: agree-counter debounce of the sampled rx bit, cleared to
// the obstacle-present state while the link is down.
module det_debounce import sim_link_pkg::*; #(
    parameter int DEBOUNCE_N = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_valid,
    input  logic i_sample,
    output logic o_det
);

    logic       r_cand;
    logic       r_det;
    logic [3:0] r_cnt;
    logic       w_cand_nxt;
    logic [3:0] w_cnt_nxt;

    always_comb begin
        w_cand_nxt = r_cand;
        w_cnt_nxt  = r_cnt;
        if (i_sample == r_cand) begin
            if (r_cnt < 4'(DEBOUNCE_N)) begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end else begin
            w_cand_nxt = i_sample;
            w_cnt_nxt  = 4'd1;
        end
    end

    // A fresh sample wins over the clear so the byte that revives the link counts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cand <= 1'b0;
            r_cnt  <= 4'd0;
            r_det  <= 1'b0;
        end else if (i_valid) begin
            r_cand <= w_cand_nxt;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == 4'(DEBOUNCE_N)) begin
                r_det <= w_cand_nxt;
            end
        end else if (i_clear) begin
            r_cand <= 1'b0;
            r_cnt  <= 4'd0;
            r_det  <= 1'b1;
        end
    end

    assign o_det = r_det;

endmodule

// File: rtl/sim_dev_link.sv
// Command/telemetry link to the simulated car: periodic and on-change command frames
// over a valid/ready tx port, debounced detector bits and a watchdog on the rx side.
module sim_dev_link import sim_link_pkg::*; #(
    parameter int         TX_PERIOD  = 100000,
    parameter int         CHANGE_TX  = 1,
    parameter int         NUM_DET    = 4,
    parameter int         DEBOUNCE_N = 3,
    parameter int         TIMEOUT    = 10000000,
    parameter logic [1:0] HDR        = 2'b10
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               power,
    input  logic [3:0]         moving_state,
    input  logic               place_barrier,
    input  logic               destroy_barrier,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic [NUM_DET-1:0] detector,
    output logic               link_up,
    output logic [15:0]        frame_cnt,
    output tx_state_t          o_dbg_tx_state
);

    localparam int PW = $clog2(TX_PERIOD);
    localparam int WW = $clog2(TIMEOUT + 1);

    // tx_valid is high exactly in SEND; a frame is accepted on tx_valid && tx_ready,
    // and tx_data does not change while tx_valid is high.
    tx_state_t    r_state, w_state_nxt;
    logic [PW-1:0] r_period;
    logic          r_held;
    logic          r_pend_place;
    logic          r_pend_destroy;
    logic [7:0]    r_tx_data;
    logic [5:0]    r_last_cmd;
    logic [15:0]   r_frame_cnt;
    logic [WW-1:0] r_wd;

    logic [3:0]         w_moving;
    logic [7:0]         w_cmd;
    logic               w_period_hit;
    logic               w_change;
    logic               w_trigger;
    logic               w_accept;
    logic               w_start;
    logic               w_link_up;
    logic [NUM_DET-1:0] w_det;
    logic               w_unused_rx;

    assign w_moving     = power ? moving_state : 4'b0000;
    assign w_cmd        = build_frame(HDR, r_pend_destroy, r_pend_place, w_moving);
    assign w_period_hit = (r_period == PW'(TX_PERIOD - 1));
    // Pulse bits are excluded so clearing a pending request does not spawn a frame.
    assign w_change     = (CHANGE_TX != 0) && ({HDR, w_moving} != r_last_cmd);
    assign w_trigger    = w_period_hit | w_change | r_held | r_pend_place | r_pend_destroy;
    assign w_accept     = (r_state == ST_SEND) && tx_ready;
    assign w_start      = (r_state == ST_IDLE) && w_trigger;

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_trigger) w_state_nxt = ST_SEND;
            ST_SEND: if (tx_ready)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_period       <= '0;
            r_held         <= 1'b0;
            r_pend_place   <= 1'b0;
            r_pend_destroy <= 1'b0;
            r_tx_data      <= 8'd0;
            r_last_cmd     <= 6'd0;
            r_frame_cnt    <= 16'd0;
        end else begin
            if (w_start || w_period_hit) begin
                r_period <= '0;
            end else begin
                r_period <= r_period + PW'(1);
            end
            if (w_start) begin
                r_held    <= 1'b0;
                r_tx_data <= w_cmd;
            end else if (w_period_hit && (r_state == ST_SEND)) begin
                r_held <= 1'b1;
            end
            if (w_accept) begin
                r_last_cmd  <= {r_tx_data[FRM_HDR_MSB:FRM_HDR_LSB], r_tx_data[FRM_MOVE_MSB:FRM_MOVE_LSB]};
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            // Only the frame that carried a request may retire it.
            r_pend_place   <= place_barrier |
                              (r_pend_place & ~(w_accept & r_tx_data[FRM_PLACE]));
            r_pend_destroy <= destroy_barrier |
                              (r_pend_destroy & ~(w_accept & r_tx_data[FRM_DESTROY]));
        end
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_wd <= '0;
        end else if (rx_valid) begin
            r_wd <= '0;
        end else if (r_wd < WW'(TIMEOUT)) begin
            r_wd <= r_wd + WW'(1);
        end
    end

    assign w_link_up = (r_wd < WW'(TIMEOUT));

    for (genvar g = 0; g < NUM_DET; g++) begin : g_det
        det_debounce #(
            .DEBOUNCE_N (DEBOUNCE_N)
        ) u_det (
            .i_clk    (sys_clk),
            .i_rst_n  (rst),
            .i_clear  (~w_link_up),
            .i_valid  (rx_valid),
            .i_sample (rx_data[g]),
            .o_det    (w_det[g])
        );
    end

    assign w_unused_rx    = ^rx_data[7:NUM_DET];
    assign tx_valid       = (r_state == ST_SEND);
    assign tx_data        = r_tx_data;
    assign frame_cnt      = r_frame_cnt;
    assign link_up        = w_link_up;
    assign detector       = w_link_up ? w_det : {NUM_DET{1'b1}};
    assign o_dbg_tx_state = r_state;

endmodule
